// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter.
// One RAM port shared between a byte writer (buffered in a small FIFO) and a
// 16-bit word reader. Reads win the port except when the FIFO has sat full
// for STARVE_LIMIT consecutive read grants, at which point one write is forced.
// Grant in cycle N, RAM issue in N+1, RAM data in N+2, rd_valid/rd_data in N+3.
module fb_port_arbiter #(
  parameter int WR_ADDR_WIDTH = 12,
  parameter int RD_ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        wr_req,
  input  logic [WR_ADDR_WIDTH-1:0]    wr_addr,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        wr_overflow,
  input  logic                        rd_req,
  input  logic [RD_ADDR_WIDTH-1:0]    rd_addr,
  output logic                        rd_ready,
  output logic [15:0]                 rd_data,
  output logic                        rd_valid,
  output logic [WR_ADDR_WIDTH-1:0]    mem_addr,
  output logic [7:0]                  mem_wdata,
  output logic                        mem_wr,
  output logic                        mem_clk_en,
  input  logic [15:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // +2 keeps the counter at least one bit wide and able to hold STARVE_LIMIT.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

  // Write FIFO storage and bookkeeping
  logic [WR_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]               fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [LVL_W-1:0]         level;
  logic                     overflow_q;

  // Arbitration state
  logic [CNT_W-1:0]         starve_cnt;
  grant_e                   grant;

  // RAM issue registers
  logic                     mem_clk_en_q;
  logic                     mem_wr_q;
  logic [WR_ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]               mem_wdata_q;

  // Read return pipeline
  logic                     rd_issue_q;
  logic                     rd_return_q;
  logic                     rd_valid_q;
  logic [15:0]              rd_data_q;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     starve_hit;
  logic                     push;
  logic                     pop;
  logic [WR_ADDR_WIDTH-1:0] head_addr;
  logic [7:0]               head_data;
  logic [WR_ADDR_WIDTH-1:0] rd_byte_addr;

  assign fifo_full    = (level == LVL_FULL);
  assign fifo_empty   = (level == '0);
  assign starve_hit   = (starve_cnt == CNT_LIMIT);
  assign head_addr    = fifo_addr[head];
  assign head_data    = fifo_data[head];
  assign rd_byte_addr = WR_ADDR_WIDTH'({rd_addr, 1'b0});

  // Space is judged on the registered level only, so a pop in the same cycle
  // never makes room for a push in that cycle.
  assign push = wr_req && !fifo_full && !reset;
  assign pop  = (grant == GNT_WRITE);

  // Per-cycle grant: read first unless starvation forces a write, else drain FIFO
  always_comb begin
    grant = GNT_IDLE;
    if (!reset) begin
      if (rd_req && !(fifo_full && starve_hit)) begin
        grant = GNT_READ;
      end else if (!fifo_empty) begin
        grant = GNT_WRITE;
      end
    end
  end

  // FIFO entry storage; contents need no reset because level gates every use
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[tail] <= wr_addr;
      fifo_data[tail] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_in) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (wr_req && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Starvation counter: counts read grants taken while the FIFO is full
  always_ff @(posedge clk_in) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant == GNT_READ && fifo_full) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // RAM issue stage: register the granted access for the following cycle
  always_ff @(posedge clk_in) begin
    if (reset) begin
      mem_clk_en_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      unique case (grant)
        GNT_READ: begin
          mem_clk_en_q <= 1'b1;
          mem_wr_q     <= 1'b0;
          mem_addr_q   <= rd_byte_addr;
          mem_wdata_q  <= '0;
        end
        GNT_WRITE: begin
          mem_clk_en_q <= 1'b1;
          mem_wr_q     <= 1'b1;
          mem_addr_q   <= head_addr;
          mem_wdata_q  <= head_data;
        end
        default: begin
          mem_clk_en_q <= 1'b0;
          mem_wr_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
        end
      endcase
    end
  end

  // Read return: track the grant through issue and RAM latency, capture data
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_issue_q  <= 1'b0;
      rd_return_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_issue_q  <= (grant == GNT_READ);
      rd_return_q <= rd_issue_q;
      rd_valid_q  <= rd_return_q;
      if (rd_return_q) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign wr_ready    = !fifo_full;
  assign wr_overflow = overflow_q;
  assign rd_ready    = (grant == GNT_READ);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign mem_clk_en  = mem_clk_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fifo_level  = level;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: directed vector table, hand-written
// starvation / overflow / reset-mid-read sequences, and randomized traffic
// against a queue-based reference model with a behavioural RAM attached.
module tb_fb_port_arbiter;
  localparam int AW    = 12;
  localparam int RW    = 11;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NTBL  = 15;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          wr_overflow;
  logic          rd_req;
  logic [RW-1:0] rd_addr;
  logic          rd_ready;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wr;
  logic          mem_clk_en;
  logic [15:0]   mem_rdata;
  logic [LW-1:0] fifo_level;

  always #5 clk_in = ~clk_in;

  fb_port_arbiter #(
    .WR_ADDR_WIDTH(AW),
    .RD_ADDR_WIDTH(RW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_overflow(wr_overflow),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_clk_en (mem_clk_en),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level)
  );

  function automatic logic [15:0] ram_init_val(input int i);
    if (i == 'h12) return 16'hBEEF;
    return 16'(i * 40503 + 7);
  endfunction

  // Behavioural RAM: 2048 words, byte writes (even byte = low half), 1-cycle read
  logic [15:0] ram_env [2048];
  logic        ram_init = 1'b1;
  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) ram_env[i] <= ram_init_val(i);
    end else if (mem_clk_en) begin
      if (mem_wr) begin
        if (mem_addr[0]) ram_env[mem_addr[11:1]][15:8] <= mem_wdata;
        else             ram_env[mem_addr[11:1]][7:0]  <= mem_wdata;
      end else begin
        mem_rdata <= ram_env[mem_addr[11:1]];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue, RAM image, read latency pipe
  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_ent_t;

  wr_ent_t     m_q[$];
  logic [15:0] m_ram [2048];
  int          m_starve;
  bit          m_ovf;
  bit          m_ok = 1'b0;
  bit          m_p1, m_p2;
  logic [15:0] m_d1, m_d2;
  bit          m_grant_rd;
  bit          e_clk_en, e_wr, e_rd_valid;
  logic [AW-1:0] e_addr;
  logic [7:0]  e_wdata;
  logic [15:0] e_rd_data;

  task automatic model_step(input bit rst, input bit wq, input logic [AW-1:0] wa,
                            input logic [7:0] wd, input bit rq, input logic [RW-1:0] ra);
    int occ;
    bit full, gw;
    wr_ent_t ent;
    if (rst) begin
      m_q.delete();
      m_starve = 0; m_ovf = 0; m_p1 = 0; m_p2 = 0; m_grant_rd = 0;
      e_clk_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      e_rd_valid = 0; e_rd_data = '0;
      m_ok = 1'b1;
      return;
    end
    occ  = m_q.size();
    full = (occ == DEPTH);
    m_grant_rd = rq && !(full && m_starve == LIMIT);
    gw = !m_grant_rd && occ > 0;
    e_rd_valid = m_p2;
    if (m_p2) e_rd_data = m_d2;
    m_p2 = m_p1; m_d2 = m_d1;
    m_p1 = m_grant_rd;
    if (m_grant_rd) m_d1 = m_ram[ra];
    e_clk_en = m_grant_rd || gw;
    e_wr = gw; e_addr = '0; e_wdata = '0;
    if (m_grant_rd) begin
      e_addr = {ra, 1'b0};
    end else if (gw) begin
      ent = m_q.pop_front();
      e_addr = ent.a; e_wdata = ent.d;
      if (ent.a[0]) m_ram[ent.a[11:1]][15:8] = ent.d;
      else          m_ram[ent.a[11:1]][7:0]  = ent.d;
    end
    m_starve = (m_grant_rd && full) ? m_starve + 1 : 0;
    if (wq) begin
      if (occ < DEPTH) m_q.push_back('{a: wa, d: wd});
      else m_ovf = 1;
    end
  endtask

  // Values observed in the most recent cycle
  logic          obs_rd_ready, obs_clk_en, obs_mem_wr, obs_rd_valid, obs_wr_ready, obs_ovf;
  logic [AW-1:0] obs_mem_addr;
  logic [7:0]    obs_wdata;
  logic [15:0]   obs_rd_data;
  logic [LW-1:0] obs_level;

  // One clock: sample registered outputs, drive inputs, check rd_ready, step model
  task automatic do_cycle(input bit rst, input bit wq, input logic [AW-1:0] wa,
                          input logic [7:0] wd, input bit rq, input logic [RW-1:0] ra);
    @(negedge clk_in);
    obs_clk_en = mem_clk_en; obs_mem_wr = mem_wr; obs_mem_addr = mem_addr;
    obs_wdata = mem_wdata; obs_rd_valid = rd_valid; obs_rd_data = rd_data;
    obs_wr_ready = wr_ready; obs_ovf = wr_overflow; obs_level = fifo_level;
    if (m_ok) begin
      chk("mem_clk_en", mem_clk_en, e_clk_en);
      chk("mem_wr", mem_wr, e_wr);
      if (e_clk_en) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("rd_valid", rd_valid, e_rd_valid);
      chk("rd_data", rd_data, e_rd_data);
      chk("wr_ready", wr_ready, m_q.size() != DEPTH);
      chk("wr_overflow", wr_overflow, m_ovf);
      chk("fifo_level", fifo_level, m_q.size());
    end
    reset = rst; wr_req = wq; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    #1;
    obs_rd_ready = rd_ready;
    model_step(rst, wq, wa, wd, rq, ra);
    chk("rd_ready", rd_ready, m_grant_rd);
    @(posedge clk_in);
  endtask

  typedef struct {
    bit            wq;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    bit            rq;
    logic [RW-1:0] ra;
    bit            e_rdy, e_en, e_wr;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wdata;
    bit            e_val;
    logic [15:0]   e_data;
    int            e_lvl;
  } vec_t;

  vec_t tbl [NTBL];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int  grants_full;
    bit  forced, valid_seen, pend;
    logic [RW-1:0] pa;

    for (int i = 0; i < 2048; i++) m_ram[i] = ram_init_val(i);
    reset = 1'b1; wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;

    //         wq wa      wd     rq ra      rdy en wr addr    wdata  val data      lvl
    tbl[0]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[1]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[2]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[3]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[4]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[5]  = '{0, 12'h0,   8'h0,  1, 11'h012, 1, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[6]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 1, 0, 12'h024, 8'h0,  0, 16'h0,    0};
    tbl[7]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'h0,    0};
    tbl[8]  = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  1, 16'hBEEF, 0};
    tbl[9]  = '{1, 12'h100, 8'hAA, 0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'hBEEF, 0};
    tbl[10] = '{1, 12'h101, 8'hBB, 0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'hBEEF, 1};
    tbl[11] = '{1, 12'h102, 8'hCC, 0, 11'h0,   0, 1, 1, 12'h100, 8'hAA, 0, 16'hBEEF, 1};
    tbl[12] = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 1, 1, 12'h101, 8'hBB, 0, 16'hBEEF, 1};
    tbl[13] = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 1, 1, 12'h102, 8'hCC, 0, 16'hBEEF, 0};
    tbl[14] = '{0, 12'h0,   8'h0,  0, 11'h0,   0, 0, 0, 12'h0,   8'h0,  0, 16'hBEEF, 0};

    do_cycle(1, 0, '0, '0, 0, '0);
    ram_init = 1'b0;
    do_cycle(1, 0, '0, '0, 0, '0);

    // Directed table: idle after reset, single read, three-byte write drain
    for (int i = 0; i < NTBL; i++) begin
      do_cycle(0, tbl[i].wq, tbl[i].wa, tbl[i].wd, tbl[i].rq, tbl[i].ra);
      chk($sformatf("tbl%0d_rd_ready", i), obs_rd_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_clk_en", i), obs_clk_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_mem_wr", i), obs_mem_wr, tbl[i].e_wr);
      if (tbl[i].e_en) begin
        chk($sformatf("tbl%0d_mem_addr", i), obs_mem_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_mem_wdata", i), obs_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("tbl%0d_rd_valid", i), obs_rd_valid, tbl[i].e_val);
      chk($sformatf("tbl%0d_rd_data", i), obs_rd_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_level", i), obs_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_wr_ready", i), obs_wr_ready, 1);
    end

    // Starvation: fill FIFO under continuous reads, expect 8 full-FIFO grants then a forced write
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 1, AW'(12'h200 + i), 8'(8'h10 + i), 1, 11'h055);
    grants_full = 0; forced = 0;
    for (int i = 0; i < 30 && !forced; i++) begin
      do_cycle(0, 0, '0, '0, 1, 11'h055);
      if (obs_rd_ready) begin
        if (obs_level == DEPTH) grants_full++;
      end else begin
        forced = 1;
      end
    end
    chk("starve_grants", grants_full, LIMIT);
    chk("starve_forced", forced, 1);
    do_cycle(0, 0, '0, '0, 1, 11'h055);
    chk("starve_resume_rdy", obs_rd_ready, 1);
    chk("forced_wr_issue", obs_mem_wr, 1);
    chk("forced_wr_addr", obs_mem_addr, 12'h200);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, '0, '0, 0, '0);
    chk("starve_drained", obs_level, 0);

    // Overflow: five pushes while reads hold the port
    for (int i = 0; i < 5; i++) do_cycle(0, 1, AW'(12'h300 + i), 8'(8'h40 + i), 1, 11'h066);
    chk("ovf_wr_ready_low", obs_wr_ready, 0);
    do_cycle(0, 0, '0, '0, 1, 11'h066);
    chk("ovf_set", obs_ovf, 1);
    chk("ovf_level", obs_level, DEPTH);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, '0, '0, 0, '0);
    chk("ovf_sticky", obs_ovf, 1);
    chk("ovf_drained", obs_level, 0);

    // Randomized traffic: light then heavy read pressure, rare resets
    pend = 0; pa = '0;
    for (int c = 0; c < 600; c++) begin
      bit rst, wq;
      rst = ($urandom_range(0, 249) == 0);
      if (!pend && $urandom_range(0, 99) < ((c < 300) ? 50 : 95)) begin
        pend = 1;
        pa = RW'($urandom);
      end
      wq = ($urandom_range(0, 99) < 45);
      do_cycle(rst, wq, AW'($urandom), 8'($urandom), pend, pa);
      if (rst || m_grant_rd) pend = 0;
    end
    for (int i = 0; i < 10; i++) do_cycle(0, 0, '0, '0, 0, '0);

    // Reset one cycle after a read grant: the read must never complete
    do_cycle(0, 1, 12'h400, 8'h77, 1, 11'h010);
    do_cycle(0, 1, 12'h401, 8'h78, 1, 11'h011);
    chk("rmr_grant", obs_rd_ready, 1);
    do_cycle(1, 0, '0, '0, 0, '0);
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, 0, '0, '0, 0, '0);
      if (obs_rd_valid) valid_seen = 1;
    end
    chk("rmr_no_valid", valid_seen, 0);
    chk("rmr_level", obs_level, 0);
    chk("rmr_ovf", obs_ovf, 0);
    chk("rmr_wr_ready", obs_wr_ready, 1);
    chk("rmr_clk_en", obs_clk_en, 0);
    chk("rmr_rd_data", obs_rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
